// File: rtl/ps2_move_decoder.sv
// rtl/ps2_move_decoder.sv - PS/2 set-2 byte stream to move pulses and held directions; define PS2_WASD_EN to add unprefixed WASD keys
module ps2_move_decoder #(
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int CNT_W          = 18
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       move_en,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic [3:0] dir_held,
    output logic       prefix_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_n;
    logic [3:0]       held_n;
    logic [3:0]       pulse_q, pulse_n;
    logic             tmo_n;
    logic [3:0]       dir_hit;
    logic             do_make;
    logic             do_break;

    // Direction bits are ordered {up, down, left, right} everywhere.
    function automatic logic [3:0] arrow_dir(input logic [7:0] code);
        case (code)
            8'h75:   arrow_dir = 4'b1000;
            8'h72:   arrow_dir = 4'b0100;
            8'h6B:   arrow_dir = 4'b0010;
            8'h74:   arrow_dir = 4'b0001;
            default: arrow_dir = 4'b0000;
        endcase
    endfunction

`ifdef PS2_WASD_EN
    function automatic logic [3:0] wasd_dir(input logic [7:0] code);
        case (code)
            8'h1D:   wasd_dir = 4'b1000;
            8'h1B:   wasd_dir = 4'b0100;
            8'h1C:   wasd_dir = 4'b0010;
            8'h23:   wasd_dir = 4'b0001;
            default: wasd_dir = 4'b0000;
        endcase
    endfunction
`endif

    // Next state, timeout counter, held set and pulse requests for this cycle.
    always_comb begin
        state_n   = state;
        tmo_cnt_n = tmo_cnt;
        held_n    = dir_held;
        pulse_n   = 4'b0000;
        tmo_n     = 1'b0;
        dir_hit   = 4'b0000;
        do_make   = 1'b0;
        do_break  = 1'b0;

        if (received_data_en) begin
            // A byte always restarts the prefix window, even on the expiry cycle.
            tmo_cnt_n = '0;
            if (received_data == 8'hE0) begin
                state_n = EXT;
            end else if (received_data == 8'hF0) begin
                state_n = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
            end else begin
                state_n = IDLE;
                case (state)
                    EXT: begin
                        dir_hit = arrow_dir(received_data);
                        do_make = 1'b1;
                    end
                    EXT_BRK: begin
                        dir_hit  = arrow_dir(received_data);
                        do_break = 1'b1;
                    end
`ifdef PS2_WASD_EN
                    IDLE: begin
                        dir_hit = wasd_dir(received_data);
                        do_make = 1'b1;
                    end
                    BRK: begin
                        dir_hit  = wasd_dir(received_data);
                        do_break = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end else if (state != IDLE) begin
            if (tmo_cnt == CNT_LAST) begin
                state_n   = IDLE;
                tmo_cnt_n = '0;
                tmo_n     = 1'b1;
            end else begin
                tmo_cnt_n = tmo_cnt + 1'b1;
            end
        end else begin
            tmo_cnt_n = '0;
        end

        // Only a press of a released key counts; typematic repeats find the bit already set.
        if (do_make && ((dir_held & dir_hit) == 4'b0000)) begin
            held_n = dir_held | dir_hit;
            if (move_en) begin
                pulse_n = dir_hit;
            end
        end
        if (do_break) begin
            held_n = dir_held & ~dir_hit;
        end
    end

    // Register state and all outputs so pulses and held bits appear one cycle after the strobe.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state          <= IDLE;
            tmo_cnt        <= '0;
            dir_held       <= 4'b0000;
            pulse_q        <= 4'b0000;
            prefix_timeout <= 1'b0;
        end else begin
            state          <= state_n;
            tmo_cnt        <= tmo_cnt_n;
            dir_held       <= held_n;
            pulse_q        <= pulse_n;
            prefix_timeout <= tmo_n;
        end
    end

    assign move_up    = pulse_q[3];
    assign move_down  = pulse_q[2];
    assign move_left  = pulse_q[1];
    assign move_right = pulse_q[0];

endmodule
